// File: rtl/vec_writeback.sv
// Writeback stage: captures the element-wise or dot-product result vector and
// commits it to the vector register file in one cycle or to data memory lane by lane.
module vec_writeback #(
  parameter int unsigned PE_COUNT       = 4,
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned RF_ADDR_WIDTH  = 4,
  parameter int unsigned MEM_ADDR_WIDTH = 10
) (
  input  logic                                clk,
  input  logic                                rstn,
  input  logic [PE_COUNT-1:0][DATA_WIDTH-1:0] elem_in,
  input  logic [PE_COUNT-1:0][DATA_WIDTH-1:0] dot_in,
  input  logic                                wb_valid,
  output logic                                wb_ready,
  input  logic                                wb_src,
  input  logic                                wb_dst,
  input  logic [RF_ADDR_WIDTH-1:0]            wb_rf_addr,
  input  logic [MEM_ADDR_WIDTH-1:0]           wb_mem_addr,
  input  logic [PE_COUNT-1:0]                 wb_lane_mask,
  output logic                                rf_we,
  output logic [RF_ADDR_WIDTH-1:0]            rf_waddr,
  output logic [PE_COUNT-1:0][DATA_WIDTH-1:0] rf_wdata,
  output logic [PE_COUNT-1:0]                 rf_wmask,
  output logic                                mem_req,
  output logic [MEM_ADDR_WIDTH-1:0]           mem_addr,
  output logic [DATA_WIDTH-1:0]               mem_wdata,
  input  logic                                mem_ack,
  output logic                                busy,
  output logic                                done
);

  localparam int unsigned LANE_W = (PE_COUNT > 1) ? $clog2(PE_COUNT) : 1;

  typedef enum logic [1:0] {IDLE, RF_WR, MEM_ST, DONE} state_e;

  state_e                                state_q, state_d;
  logic [PE_COUNT-1:0][DATA_WIDTH-1:0]   buf_q, buf_d;
  logic [MEM_ADDR_WIDTH-1:0]             base_q, base_d;
  logic [PE_COUNT-1:0]                   mask_q, mask_d;

  logic                                  wb_ready_q, wb_ready_d;
  logic                                  rf_we_q, rf_we_d;
  logic [RF_ADDR_WIDTH-1:0]              rf_waddr_q, rf_waddr_d;
  logic [PE_COUNT-1:0][DATA_WIDTH-1:0]   rf_wdata_q, rf_wdata_d;
  logic [PE_COUNT-1:0]                   rf_wmask_q, rf_wmask_d;
  logic                                  mem_req_q, mem_req_d;
  logic [MEM_ADDR_WIDTH-1:0]             mem_addr_q, mem_addr_d;
  logic [DATA_WIDTH-1:0]                 mem_wdata_q, mem_wdata_d;
  logic                                  busy_q, busy_d;
  logic                                  done_q, done_d;

  logic [LANE_W-1:0]                     lane;

  // Index of the lowest set bit; memory lanes are issued in ascending order.
  function automatic logic [LANE_W-1:0] low_lane(input logic [PE_COUNT-1:0] m);
    low_lane = '0;
    for (int i = PE_COUNT - 1; i >= 0; i--) begin
      if (m[i]) low_lane = LANE_W'(i);
    end
  endfunction

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q     <= IDLE;
      buf_q       <= '0;
      base_q      <= '0;
      mask_q      <= '0;
      wb_ready_q  <= 1'b1;
      rf_we_q     <= 1'b0;
      rf_waddr_q  <= '0;
      rf_wdata_q  <= '0;
      rf_wmask_q  <= '0;
      mem_req_q   <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      buf_q       <= buf_d;
      base_q      <= base_d;
      mask_q      <= mask_d;
      wb_ready_q  <= wb_ready_d;
      rf_we_q     <= rf_we_d;
      rf_waddr_q  <= rf_waddr_d;
      rf_wdata_q  <= rf_wdata_d;
      rf_wmask_q  <= rf_wmask_d;
      mem_req_q   <= mem_req_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  // Outputs are computed against the next state so they are registered yet cycle-aligned.
  always_comb begin
    state_d     = state_q;
    buf_d       = buf_q;
    base_d      = base_q;
    mask_d      = mask_q;
    rf_we_d     = 1'b0;
    rf_waddr_d  = rf_waddr_q;
    rf_wdata_d  = rf_wdata_q;
    rf_wmask_d  = rf_wmask_q;
    mem_req_d   = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    done_d      = 1'b0;
    lane        = '0;

    case (state_q)
      IDLE: begin
        if (wb_valid) begin
          buf_d  = wb_src ? dot_in : elem_in;
          base_d = wb_mem_addr;
          mask_d = wb_lane_mask;
          if (!wb_dst) begin
            state_d    = RF_WR;
            rf_we_d    = 1'b1;
            rf_waddr_d = wb_rf_addr;
            rf_wdata_d = buf_d;
            rf_wmask_d = wb_lane_mask;
          end else if (wb_lane_mask == '0) begin
            state_d = DONE;
            done_d  = 1'b1;
          end else begin
            state_d     = MEM_ST;
            lane        = low_lane(wb_lane_mask);
            mem_req_d   = 1'b1;
            mem_addr_d  = wb_mem_addr + MEM_ADDR_WIDTH'(lane);
            mem_wdata_d = buf_d[lane];
          end
        end
      end
      RF_WR: begin
        state_d = DONE;
        done_d  = 1'b1;
      end
      MEM_ST: begin
        mem_req_d = 1'b1;
        if (mem_ack) begin
          // m & (m-1) retires the lowest pending lane.
          mask_d = mask_q & (mask_q - PE_COUNT'(1));
          if (mask_d == '0) begin
            state_d   = DONE;
            done_d    = 1'b1;
            mem_req_d = 1'b0;
          end else begin
            lane        = low_lane(mask_d);
            mem_addr_d  = base_q + MEM_ADDR_WIDTH'(lane);
            mem_wdata_d = buf_q[lane];
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d     = (state_d != IDLE);
    wb_ready_d = (state_d == IDLE);
  end

  assign wb_ready  = wb_ready_q;
  assign rf_we     = rf_we_q;
  assign rf_waddr  = rf_waddr_q;
  assign rf_wdata  = rf_wdata_q;
  assign rf_wmask  = rf_wmask_q;
  assign mem_req   = mem_req_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule

// File: tb/tb_vec_writeback.sv
// Directed bench for vec_writeback: table of RF writes plus hand sequences for
// memory stores, backpressure, address wrap, zero mask and mid-operation reset.
module tb_vec_writeback;

  logic               clk;
  logic               rstn;
  logic [3:0][31:0]   elem_in;
  logic [3:0][31:0]   dot_in;
  logic               wb_valid;
  logic               wb_ready;
  logic               wb_src;
  logic               wb_dst;
  logic [3:0]         wb_rf_addr;
  logic [9:0]         wb_mem_addr;
  logic [3:0]         wb_lane_mask;
  logic               rf_we;
  logic [3:0]         rf_waddr;
  logic [3:0][31:0]   rf_wdata;
  logic [3:0]         rf_wmask;
  logic               mem_req;
  logic [9:0]         mem_addr;
  logic [31:0]        mem_wdata;
  logic               mem_ack;
  logic               busy;
  logic               done;

  int passed;
  int total;

  vec_writeback dut (
    .clk         (clk),
    .rstn        (rstn),
    .elem_in     (elem_in),
    .dot_in      (dot_in),
    .wb_valid    (wb_valid),
    .wb_ready    (wb_ready),
    .wb_src      (wb_src),
    .wb_dst      (wb_dst),
    .wb_rf_addr  (wb_rf_addr),
    .wb_mem_addr (wb_mem_addr),
    .wb_lane_mask(wb_lane_mask),
    .rf_we       (rf_we),
    .rf_waddr    (rf_waddr),
    .rf_wdata    (rf_wdata),
    .rf_wmask    (rf_wmask),
    .mem_req     (mem_req),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .mem_ack     (mem_ack),
    .busy        (busy),
    .done        (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  typedef struct {
    logic         src;
    logic [3:0]   rf_addr;
    logic [3:0]   mask;
    logic [127:0] elem;
    logic [127:0] dot;
    logic [127:0] exp_wdata;
  } rf_vec_t;

  rf_vec_t tbl [4];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  task automatic accept(input logic src, input logic dst, input logic [3:0] ra,
                        input logic [9:0] ma, input logic [3:0] mask);
    wb_valid     = 1'b1;
    wb_src       = src;
    wb_dst       = dst;
    wb_rf_addr   = ra;
    wb_mem_addr  = ma;
    wb_lane_mask = mask;
    step();
    wb_valid     = 1'b0;
    elem_in      = {4{32'hDEAD_BEEF}};
    dot_in       = {4{32'hBAD0_C0DE}};
  endtask

  task automatic mem_chk(input string tag, input logic [9:0] a, input logic [31:0] d);
    chk({tag, "_req"},  128'(mem_req),   128'd1);
    chk({tag, "_addr"}, 128'(mem_addr),  128'(a));
    chk({tag, "_data"}, 128'(mem_wdata), 128'(d));
    chk({tag, "_done"}, 128'(done),      128'd0);
  endtask

  initial begin
    passed       = 0;
    total        = 0;
    rstn         = 1'b0;
    wb_valid     = 1'b1;
    wb_src       = 1'b0;
    wb_dst       = 1'b0;
    wb_rf_addr   = 4'd7;
    wb_mem_addr  = 10'h055;
    wb_lane_mask = 4'hF;
    elem_in      = {32'd4, 32'd3, 32'd2, 32'd1};
    dot_in       = '0;
    mem_ack      = 1'b0;

    tbl[0] = '{src: 1'b0, rf_addr: 4'd5, mask: 4'b1111,
               elem: {32'd4, 32'd3, 32'd2, 32'd1}, dot: {4{32'h0000_FFFF}},
               exp_wdata: {32'd4, 32'd3, 32'd2, 32'd1}};
    tbl[1] = '{src: 1'b1, rf_addr: 4'hA, mask: 4'b0101,
               elem: {4{32'h1111_1111}}, dot: {32'h4000_0004, 32'h3000_0003, 32'h2000_0002, 32'h1000_0001},
               exp_wdata: {32'h4000_0004, 32'h3000_0003, 32'h2000_0002, 32'h1000_0001}};
    tbl[2] = '{src: 1'b0, rf_addr: 4'hF, mask: 4'b0000,
               elem: {32'hFFFF_FFFF, 32'h0, 32'h8000_0000, 32'h7FFF_FFFF}, dot: {4{32'h2222_2222}},
               exp_wdata: {32'hFFFF_FFFF, 32'h0, 32'h8000_0000, 32'h7FFF_FFFF}};
    tbl[3] = '{src: 1'b1, rf_addr: 4'h0, mask: 4'b1000,
               elem: {4{32'h3333_3333}}, dot: {32'hCAFE_0003, 32'hCAFE_0002, 32'hCAFE_0001, 32'hCAFE_0000},
               exp_wdata: {32'hCAFE_0003, 32'hCAFE_0002, 32'hCAFE_0001, 32'hCAFE_0000}};

    // Reset held two cycles with a request pending
    for (int c = 0; c < 2; c++) begin
      step();
      chk($sformatf("rst%0d_ready", c), 128'(wb_ready), 128'd1);
      chk($sformatf("rst%0d_rf_we", c), 128'(rf_we),    128'd0);
      chk($sformatf("rst%0d_req", c),   128'(mem_req),  128'd0);
      chk($sformatf("rst%0d_done", c),  128'(done),     128'd0);
      chk($sformatf("rst%0d_busy", c),  128'(busy),     128'd0);
    end
    chk("rst_waddr", 128'(rf_waddr), 128'd0);
    chk("rst_wdata", rf_wdata,        128'd0);
    chk("rst_wmask", 128'(rf_wmask), 128'd0);
    chk("rst_maddr", 128'(mem_addr), 128'd0);
    chk("rst_mdata", 128'(mem_wdata), 128'd0);
    rstn     = 1'b1;
    wb_valid = 1'b0;
    step();
    chk("post_rst_busy",  128'(busy),  128'd0);
    chk("post_rst_rf_we", 128'(rf_we), 128'd0);

    // RF write table
    for (int i = 0; i < 4; i++) begin
      elem_in = tbl[i].elem;
      dot_in  = tbl[i].dot;
      accept(tbl[i].src, 1'b0, tbl[i].rf_addr, 10'h000, tbl[i].mask);
      chk($sformatf("rf%0d_we", i),    128'(rf_we),    128'd1);
      chk($sformatf("rf%0d_waddr", i), 128'(rf_waddr), 128'(tbl[i].rf_addr));
      chk($sformatf("rf%0d_wdata", i), rf_wdata,       tbl[i].exp_wdata);
      chk($sformatf("rf%0d_wmask", i), 128'(rf_wmask), 128'(tbl[i].mask));
      chk($sformatf("rf%0d_busy", i),  128'(busy),     128'd1);
      chk($sformatf("rf%0d_ready", i), 128'(wb_ready), 128'd0);
      chk($sformatf("rf%0d_req", i),   128'(mem_req),  128'd0);
      chk($sformatf("rf%0d_done0", i), 128'(done),     128'd0);
      step();
      chk($sformatf("rf%0d_we_off", i), 128'(rf_we),    128'd0);
      chk($sformatf("rf%0d_done", i),   128'(done),     128'd1);
      chk($sformatf("rf%0d_ready1", i), 128'(wb_ready), 128'd0);
      step();
      chk($sformatf("rf%0d_done_off", i), 128'(done),     128'd0);
      chk($sformatf("rf%0d_ready2", i),   128'(wb_ready), 128'd1);
      chk($sformatf("rf%0d_idle", i),     128'(busy),     128'd0);
    end

    // MEM store, full mask, ack tied high (ack while idle is ignored)
    mem_ack = 1'b1;
    elem_in = {4{32'h5555_5555}};
    dot_in  = {32'hDDDD_0004, 32'hCCCC_0003, 32'hBBBB_0002, 32'hAAAA_0001};
    accept(1'b1, 1'b1, 4'd0, 10'h100, 4'b1111);
    mem_chk("full0", 10'h100, 32'hAAAA_0001);
    chk("full0_busy", 128'(busy), 128'd1);
    chk("full0_rf_we", 128'(rf_we), 128'd0);
    step();
    mem_chk("full1", 10'h101, 32'hBBBB_0002);
    step();
    mem_chk("full2", 10'h102, 32'hCCCC_0003);
    step();
    mem_chk("full3", 10'h103, 32'hDDDD_0004);
    step();
    chk("full_req_off", 128'(mem_req), 128'd0);
    chk("full_done",    128'(done),    128'd1);
    step();
    chk("full_done_off", 128'(done),     128'd0);
    chk("full_ready",    128'(wb_ready), 128'd1);
    mem_ack = 1'b0;

    // Sparse mask 1010 with two-cycle ack delay and address wrap at 0x3FF
    elem_in = {32'hE333_0003, 32'hE222_0002, 32'hE111_0001, 32'hE000_0000};
    dot_in  = {4{32'h6666_6666}};
    accept(1'b0, 1'b1, 4'd0, 10'h3FF, 4'b1010);
    mem_chk("sp1_c0", 10'h000, 32'hE111_0001);
    step();
    mem_chk("sp1_c1", 10'h000, 32'hE111_0001);
    step();
    mem_chk("sp1_c2", 10'h000, 32'hE111_0001);
    mem_ack = 1'b1;
    step();
    mem_ack = 1'b0;
    mem_chk("sp3_c0", 10'h002, 32'hE333_0003);
    step();
    mem_chk("sp3_c1", 10'h002, 32'hE333_0003);
    step();
    mem_chk("sp3_c2", 10'h002, 32'hE333_0003);
    mem_ack = 1'b1;
    step();
    mem_ack = 1'b0;
    chk("sp_req_off", 128'(mem_req), 128'd0);
    chk("sp_done",    128'(done),    128'd1);
    step();
    chk("sp_ready", 128'(wb_ready), 128'd1);

    // Zero mask to memory: no request, done straight away
    accept(1'b0, 1'b1, 4'd0, 10'h040, 4'b0000);
    chk("zm_req",  128'(mem_req), 128'd0);
    chk("zm_done", 128'(done),    128'd1);
    step();
    chk("zm_req1",  128'(mem_req),  128'd0);
    chk("zm_ready", 128'(wb_ready), 128'd1);

    // Abort with reset while lane 2 is pending
    mem_ack = 1'b1;
    dot_in  = {32'hF000_0003, 32'hF000_0002, 32'hF000_0001, 32'hF000_0000};
    accept(1'b1, 1'b1, 4'd0, 10'h020, 4'b1111);
    step();
    step();
    mem_ack = 1'b0;
    mem_chk("ab_lane2", 10'h022, 32'hF000_0002);
    rstn = 1'b0;
    step();
    rstn = 1'b1;
    chk("ab_req",   128'(mem_req),  128'd0);
    chk("ab_done",  128'(done),     128'd0);
    chk("ab_busy",  128'(busy),     128'd0);
    chk("ab_ready", 128'(wb_ready), 128'd1);
    chk("ab_addr",  128'(mem_addr), 128'd0);
    step();
    chk("ab_done_after", 128'(done),    128'd0);
    chk("ab_req_after",  128'(mem_req), 128'd0);

    elem_in = {32'd40, 32'd30, 32'd20, 32'd10};
    accept(1'b0, 1'b0, 4'd3, 10'h000, 4'b0011);
    chk("ab_rf_we",    128'(rf_we),    128'd1);
    chk("ab_rf_waddr", 128'(rf_waddr), 128'd3);
    chk("ab_rf_wdata", rf_wdata,       {32'd40, 32'd30, 32'd20, 32'd10});
    chk("ab_rf_wmask", 128'(rf_wmask), 128'h3);
    step();
    chk("ab_rf_done", 128'(done), 128'd1);
    step();
    chk("ab_rf_ready", 128'(wb_ready), 128'd1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/vec_writeback.md
# vec_writeback

Writeback stage directly downstream of the execute unit. Captures either the element-wise result vector or the dot-product result vector and commits it to one of two destinations. The vector register file takes the whole vector in one write cycle. Data memory takes one lane per request over a valid/ack port, skipping masked-off lanes. Holds one operation at a time and reports completion with a single-cycle pulse.

## Interface
- PE_COUNT, 4, number of lanes/PEs
- DATA_WIDTH, 32, bits per lane
- RF_ADDR_WIDTH, 4, vector register index width
- MEM_ADDR_WIDTH, 10, data memory word address width
- clk  in  1  clock
- rstn  in  1  reset; synchronous, active-low
- elem_in  in  [PE_COUNT][DATA_WIDTH]  element-wise result vector
- dot_in  in  [PE_COUNT][DATA_WIDTH]  dot-product result vector
- wb_valid  in  1  writeback request
- wb_ready  out  1  block can accept a request
- wb_src  in  1  0 = elem_in, 1 = dot_in
- wb_dst  in  1  0 = register file, 1 = data memory
- wb_rf_addr  in  RF_ADDR_WIDTH  destination vector register
- wb_mem_addr  in  MEM_ADDR_WIDTH  base word address for lane 0
- wb_lane_mask  in  PE_COUNT  per-lane write enable; bit i = lane i
- rf_we  out  1  register file write strobe
- rf_waddr  out  RF_ADDR_WIDTH  register file write address
- rf_wdata  out  [PE_COUNT][DATA_WIDTH]  register file write data
- rf_wmask  out  PE_COUNT  register file lane mask
- mem_req  out  1  memory write request
- mem_addr  out  MEM_ADDR_WIDTH  memory word address
- mem_wdata  out  DATA_WIDTH  memory write data
- mem_ack  in  1  memory accepted current request
- busy  out  1  state != IDLE
- done  out  1  one-cycle completion pulse

## Operation
- States: IDLE, RF_WR, MEM_ST, DONE.
- IDLE: wb_ready=1. On wb_valid&&wb_ready, the block registers the following:
  - data buffer = wb_src ? dot_in : elem_in
  - dest address, base address, lane mask into the remaining-mask register
  - next state = wb_dst ? MEM_ST : RF_WR
- RF_WR, one cycle:
  - rf_we=1, rf_waddr/rf_wdata/rf_wmask from captured values
  - next state DONE
  - An all-zero mask still issues rf_we with rf_wmask=0.
- MEM_ST:
  - Current lane = lowest set bit of the remaining mask.
  - mem_req=1, mem_addr = base + lane (modulo 2^MEM_ADDR_WIDTH), mem_wdata = buffer[lane].
  - On mem_ack: clear that bit. If the mask is now zero, go to DONE; otherwise stay and present the next lane the following cycle.
  - Without mem_ack, mem_req/addr/wdata hold stable.
  - A zero mask on entry goes straight to DONE with no mem_req.
- DONE: done=1 for one cycle, then IDLE.
- The buffer is a register, so inputs may change freely after acceptance.
- mem_ack outside MEM_ST is ignored.
- wb_valid in any state other than IDLE is ignored; the request is not queued, and the upstream holds it until wb_ready.

## Timing
- Reset (rstn=0 at a clk edge):
  - state IDLE
  - wb_ready=1
  - rf_we, mem_req, done, busy = 0
  - rf_waddr, rf_wdata, rf_wmask, mem_addr, mem_wdata = 0
  - buffer and remaining mask cleared
- Reset mid-operation aborts immediately. mem_req drops in the cycle after the reset edge, and no done is pulsed.
- RF path: accept at edge N → rf_we high in cycle N+1 → done in cycle N+2 → wb_ready high in cycle N+3.
- MEM path: accept at edge N → first mem_req in cycle N+1.
  - Each lane takes ≥1 cycle: one cycle when mem_ack is high in the first request cycle.
  - done appears in the cycle after the final ack.
  - k enabled lanes with immediate ack: done in cycle N+1+k, ready in N+2+k.
- All outputs are driven from registers or the state register; there is no combinational path from inputs to outputs.

## Test plan
- Reset: hold rstn=0 for 2 cycles while driving wb_valid=1 → wb_ready=1, rf_we=mem_req=done=busy=0, and no request is accepted.
- RF write: wb_src=0, wb_dst=0, wb_rf_addr=5, mask=4'b1111, elem_in={4,3,2,1} → one rf_we pulse with waddr=5 and wdata={4,3,2,1}; done 1 cycle later; ready on the 3rd cycle.
- MEM store, full mask, mem_ack tied 1: wb_src=1, base=0x100, dot_in={D,C,B,A} → mem_addr 0x100,0x101,0x102,0x103 on consecutive cycles with data A,B,C,D, then a done pulse.
- Sparse mask with backpressure: mask=4'b1010, base=0x3FF, ack delayed 2 cycles per request → lane 1 at 0x000 (wrap), then lane 3 at 0x002; addr/data stable while waiting; exactly 2 requests.
- Zero mask to MEM: mask=0 → no mem_req; done in the cycle after acceptance.
- Abort: reset asserted while the lane-2 request is pending → mem_req=0 next cycle, no done, state IDLE. A subsequent RF request completes normally.
